video_frame_sink: RTL and testbench
===================================

# video_frame_sink

Stream receiver that terminates the pixel valid/ready/last interface driven by the team's video source models. It captures exactly one active frame per arm into on-chip frame memory and checks that `last` falls on the final pixel. It accumulates a checksum and exposes a registered read port so the bench or downstream rectify logic can inspect captured pixels. An optional LFSR-driven ready throttle exercises source backpressure.

## Interface
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame; frame size N = H_ACTIVE*V_ACTIVE
- `DATA_W`, 8, pixel width
- `STALL_EN`, 0, 1 = throttle `vrready` with LFSR, 0 = ready whenever receiving
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  arm capture; sampled in IDLE or DONE only
- `vrdata`  in  DATA_W  pixel data
- `vrvalid`  in  1  source beat valid
- `vrlast`  in  1  source end-of-frame marker
- `vrready`  out  1  sink ready (registered)
- `rd_addr`  in  ADDR_W=$clog2(N)  capture-memory read address
- `rd_data`  out  DATA_W  memory data, 1-cycle latency
- `busy`  out  1  high in RECV
- `frame_done`  out  1  one-cycle pulse on correct frame completion
- `err_early_last`  out  1  sticky: `vrlast` before pixel N-1
- `err_missing_last`  out  1  sticky: pixel N-1 without `vrlast`
- `pix_count`  out  ADDR_W+1  beats accepted this frame
- `checksum`  out  32  modulo-2^32 sum of accepted pixels

## Operation
- Beat = `vrvalid && vrready` at a rising edge.
- States: IDLE, RECV, DONE. Encoding 2 bits.
- IDLE: `vrready`=0. On `start` -> RECV; clear `pix_count`, `checksum`, both error flags, write address.
- RECV: on each beat, write `vrdata` to mem[wr_addr], increment wr_addr and `pix_count`, and add `vrdata` zero-extended to `checksum`.
  - Beat with `vrlast` and wr_addr==N-1 -> DONE, pulse `frame_done`.
  - Beat with `vrlast` and wr_addr<N-1 -> set `err_early_last`, -> DONE, no `frame_done`.
  - Beat at wr_addr==N-1 without `vrlast` -> set `err_missing_last`, -> DONE, no `frame_done`.
  - `start` ignored in RECV.
- DONE: `vrready`=0. Results are held. `start` re-arms exactly as from IDLE.
- Ready: in RECV, `vrready` = 1 when STALL_EN=0, or LFSR[1]|LFSR[0] when STALL_EN=1 (~75% duty). The LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, and advances every cycle in RECV. `vrready` never depends combinationally on `vrvalid`.
- Memory is not cleared by reset or `start`. Pixels of an aborted frame remain.
- Read port is read-first: `rd_data` returns the old content when `rd_addr` equals the address written in the same cycle. It is valid in every state.

## Timing
- Reset values: state IDLE, `vrready` 0, `busy` 0, `frame_done` 0, errors 0, `pix_count` 0, `checksum` 0, LFSR seed, `rd_data` 0.
- `start` at edge k -> RECV and `vrready` high (STALL_EN=0) from cycle k+1.
- The terminating beat at edge k makes DONE, `frame_done` (1 cycle), and `vrready`=0 effective from cycle k+1. No beat is accepted after the terminating one.
- `pix_count`/`checksum` reflect the beat at edge k from cycle k+1.
- `rd_addr` at edge k -> `rd_data` valid after edge k+1.
- `rst_n` low mid-frame: all outputs return to reset values immediately (asynchronous). The partial frame is abandoned.

## Structure
- Package `video_pkg`: H_ACTIVE/V_ACTIVE defaults, FRAME_PIX, state enum, LFSR seed/taps.
- Sub-module `frame_ram`: simple dual-port, N x DATA_W, sync write, registered read-first read. The top holds the FSM, counters, checker, and LFSR.

## Test plan
- H=4,V=2, STALL_EN=0, pixels 1..8, `vrlast` on 8th -> `frame_done` once, `pix_count`=8, `checksum`=36, rd_addr 0..7 returns 1..8.
- H=4,V=2, `vrlast` on 5th beat -> `err_early_last`=1, `pix_count`=5, no `frame_done`, `vrready` 0 next cycle.
- H=4,V=2, no `vrlast` on 8 beats -> `err_missing_last`=1, `pix_count`=8, 9th valid never accepted.
- STALL_EN=1, source holds valid with random gaps -> every beat captured once in order, `checksum` matches the model, and `vrready` toggles.
- Full 640x480 frame of the pattern (i mod 256) -> `frame_done`, `pix_count`=307200, `checksum`=39168000.
- `rst_n` pulsed after 3 beats, then `start` and a full 8-pixel frame -> the second frame is correct and the errors are clear.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the video frame sink: default frame geometry,
// capture FSM state codes and the ready-throttle LFSR parameters.
// No ports; imported by video_frame_sink and frame_ram.
package video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FRAME_PIX    = H_ACTIVE_DEF * V_ACTIVE_DEF;

    // Capture FSM encoding, kept as plain 2-bit constants so older tools
    // and hand-written monitors can compare against raw values.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/frame_ram.sv
// frame_ram
// Simple dual-port capture memory, DEPTH x DATA_W. Synchronous write,
// registered read with read-first behaviour on an address collision.
// Ports:
//   clk, rst_n       clock / async active-low reset (read register only)
//   wr_en, wr_addr, wr_data   write port
//   rd_addr, rd_data          read port, one cycle latency
module frame_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately never cleared so pixels of an aborted frame
    // stay inspectable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read alongside the write gives old data on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_frame_sink.sv
// video_frame_sink
// Terminates a valid/ready/last pixel stream, capturing one frame per
// start into frame_ram, checking that last lands on the final pixel and
// summing the accepted pixels.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   start                          arm a capture (honoured in IDLE/DONE)
//   vrdata, vrvalid, vrlast        source beat
//   vrready                        registered sink ready
//   rd_addr, rd_data               capture memory read port (1-cycle)
//   busy                           receiving a frame
//   frame_done                     one-cycle pulse, frame ended correctly
//   err_early_last, err_missing_last   sticky framing errors
//   pix_count, checksum            beats accepted / sum of pixels
module video_frame_sink
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DATA_W   = 8,
    parameter int STALL_EN = 0,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] vrdata,
    input  logic              vrvalid,
    input  logic              vrlast,
    output logic              vrready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_early_last,
    output logic              err_missing_last,
    output logic [ADDR_W:0]   pix_count,
    output logic [31:0]       checksum
);

    localparam int                N         = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic              ready_nxt;
    logic              beat;
    logic              at_last_addr;
    logic              term;
    logic              arm;

    assign beat         = vrvalid && vrready && (state == ST_RECV);
    assign at_last_addr = (wr_addr == LAST_ADDR);
    assign term         = beat && (vrlast || at_last_addr);
    assign arm          = start && (state != ST_RECV);
    assign busy         = (state == ST_RECV);

    // A terminating beat and a start can never coincide, since start is
    // only honoured outside RECV.
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ST_RECV;
        end else if (term) begin
            state_nxt = ST_DONE;
        end
    end

    // Ready is registered from next-state and next-LFSR, so it drops on
    // the cycle right after the terminating beat and never looks at vrvalid.
    always_comb begin
        lfsr_nxt  = (state == ST_RECV) ? lfsr_step(lfsr) : lfsr;
        ready_nxt = (state_nxt == ST_RECV) &&
                    ((STALL_EN == 0) || lfsr_nxt[1] || lfsr_nxt[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            lfsr             <= LFSR_SEED;
            vrready          <= 1'b0;
            frame_done       <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            wr_addr          <= '0;
            pix_count        <= '0;
            checksum         <= '0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            vrready    <= ready_nxt;
            frame_done <= 1'b0;
            if (arm) begin
                err_early_last   <= 1'b0;
                err_missing_last <= 1'b0;
                wr_addr          <= '0;
                pix_count        <= '0;
                checksum         <= '0;
            end else if (beat) begin
                wr_addr   <= wr_addr + ADDR_ONE;
                pix_count <= pix_count + CNT_ONE;
                checksum  <= checksum + 32'(vrdata);
                if (vrlast && at_last_addr) begin
                    frame_done <= 1'b1;
                end else if (vrlast) begin
                    err_early_last <= 1'b1;
                end else if (at_last_addr) begin
                    err_missing_last <= 1'b1;
                end
            end
        end
    end

    frame_ram #(
        .DEPTH  (N),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat),
        .wr_addr (wr_addr),
        .wr_data (vrdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_video_frame_sink.sv
// tb_video_frame_sink
// Self-checking bench for video_frame_sink. Three instances share clk and
// rst_n: a 4x2 unthrottled sink for framing cases, a 4x4 LFSR-throttled
// sink for backpressure, and a 160x120 sink for a long frame.
module tb_video_frame_sink;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int vec_count = 0;
    int miscount  = 0;

    // ---------------- small instance: 4x2, no throttle ----------------
    logic        s_start, s_valid, s_last, s_ready;
    logic [7:0]  s_data, s_rd_data;
    logic [2:0]  s_rd_addr;
    logic        s_busy, s_done, s_early, s_missing;
    logic [3:0]  s_count;
    logic [31:0] s_checksum;

    video_frame_sink #(.H_ACTIVE(4), .V_ACTIVE(2), .DATA_W(8), .STALL_EN(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .vrdata(s_data),
        .vrvalid(s_valid), .vrlast(s_last), .vrready(s_ready),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data), .busy(s_busy),
        .frame_done(s_done), .err_early_last(s_early),
        .err_missing_last(s_missing), .pix_count(s_count), .checksum(s_checksum)
    );

    // ---------------- stall instance: 4x4, LFSR throttle ----------------
    logic        t_start, t_valid, t_last, t_ready;
    logic [7:0]  t_data, t_rd_data;
    logic [3:0]  t_rd_addr;
    logic        t_busy, t_done, t_early, t_missing;
    logic [4:0]  t_count;
    logic [31:0] t_checksum;

    video_frame_sink #(.H_ACTIVE(4), .V_ACTIVE(4), .DATA_W(8), .STALL_EN(1)) u_stall (
        .clk(clk), .rst_n(rst_n), .start(t_start), .vrdata(t_data),
        .vrvalid(t_valid), .vrlast(t_last), .vrready(t_ready),
        .rd_addr(t_rd_addr), .rd_data(t_rd_data), .busy(t_busy),
        .frame_done(t_done), .err_early_last(t_early),
        .err_missing_last(t_missing), .pix_count(t_count), .checksum(t_checksum)
    );

    // ---------------- big instance: 160x120, no throttle ----------------
    logic        b_start, b_valid, b_last, b_ready;
    logic [7:0]  b_data, b_rd_data;
    logic [14:0] b_rd_addr;
    logic        b_busy, b_done, b_early, b_missing;
    logic [15:0] b_count;
    logic [31:0] b_checksum;

    video_frame_sink #(.H_ACTIVE(160), .V_ACTIVE(120), .DATA_W(8), .STALL_EN(0)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .vrdata(b_data),
        .vrvalid(b_valid), .vrlast(b_last), .vrready(b_ready),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .busy(b_busy),
        .frame_done(b_done), .err_early_last(b_early),
        .err_missing_last(b_missing), .pix_count(b_count), .checksum(b_checksum)
    );

    // Pulse and stall monitors, sampled mid-cycle.
    int s_done_pulses = 0;
    int t_done_pulses = 0;
    int b_done_pulses = 0;
    int t_stall_cycles = 0;

    always @(negedge clk) begin
        if (s_done) s_done_pulses++;
        if (t_done) t_done_pulses++;
        if (b_done) b_done_pulses++;
        if (t_busy && !t_ready) t_stall_cycles++;
    end

    // Scoreboards: expected capture-memory contents in address order.
    logic [7:0] s_q[$];
    logic [7:0] t_q[$];

    typedef struct {
        int n_beats;
        int last_pos;
        int base;
        int exp_count;
        int exp_sum;
        int exp_done;
        int exp_early;
        int exp_missing;
        int readback;
    } vec_t;

    vec_t vecs[5];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Arms the small sink and sends n_beats pixels base, base+1, ...
    // with last on beat last_pos (0 = never). A beat not taken within
    // 10 cycles ends the frame; accepted beats go to the scoreboard.
    task automatic apply_stimulus(input int n_beats, input int last_pos,
                                  input int base, output int accepted);
        logic got;
        accepted = 0;
        s_q.delete();
        s_done_pulses = 0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int i = 1; i <= n_beats; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(base + i - 1);
            s_last  = (i == last_pos);
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                got = s_ready;
                @(posedge clk); #1;
            end
            if (!got) break;
            accepted++;
            s_q.push_back(s_data);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic read_small(input int addr, output logic [7:0] data);
        @(posedge clk); #1 s_rd_addr = 3'(addr);
        @(posedge clk);
        @(negedge clk);
        data = s_rd_data;
    endtask

    initial begin
        int          accepted;
        logic [7:0]  rd;
        logic [7:0]  exp_pix;
        logic [31:0] model_sum;
        logic        got;
        int          gap;

        vecs[0] = '{8, 8, 1,   8, 36,  1, 0, 0, 1};
        vecs[1] = '{5, 5, 1,   5, 15,  0, 1, 0, 0};
        vecs[2] = '{9, 0, 1,   8, 36,  0, 0, 1, 0};
        vecs[3] = '{1, 1, 200, 1, 200, 0, 1, 0, 0};
        vecs[4] = '{8, 8, 100, 8, 828, 1, 0, 0, 1};

        rst_n = 1'b0;
        s_start = 0; s_valid = 0; s_last = 0; s_data = 0; s_rd_addr = 0;
        t_start = 0; t_valid = 0; t_last = 0; t_data = 0; t_rd_addr = 0;
        b_start = 0; b_valid = 0; b_last = 0; b_data = 0; b_rd_addr = 0;

        // Reset values.
        #23;
        check_output("rst_ready",    {31'd0, s_ready},   0);
        check_output("rst_busy",     {31'd0, s_busy},    0);
        check_output("rst_done",     {31'd0, s_done},    0);
        check_output("rst_errs",     {30'd0, s_early, s_missing}, 0);
        check_output("rst_count",    {28'd0, s_count},   0);
        check_output("rst_checksum", s_checksum,         0);
        check_output("rst_rd_data",  {24'd0, s_rd_data}, 0);
        check_output("rst_t_ready",  {31'd0, t_ready},   0);
        @(negedge clk) rst_n = 1'b1;

        // Table of framing cases on the small sink.
        foreach (vecs[v]) begin
            apply_stimulus(vecs[v].n_beats, vecs[v].last_pos, vecs[v].base, accepted);
            @(negedge clk);
            check_output($sformatf("v%0d_ready_after", v), {31'd0, s_ready}, 0);
            check_output($sformatf("v%0d_busy_after", v),  {31'd0, s_busy},  0);
            repeat (2) @(negedge clk);
            check_output($sformatf("v%0d_accepted", v), accepted, vecs[v].exp_count);
            check_output($sformatf("v%0d_count", v), {28'd0, s_count}, vecs[v].exp_count);
            check_output($sformatf("v%0d_checksum", v), s_checksum, vecs[v].exp_sum);
            check_output($sformatf("v%0d_done_pulses", v), s_done_pulses, vecs[v].exp_done);
            check_output($sformatf("v%0d_early", v), {31'd0, s_early}, vecs[v].exp_early);
            check_output($sformatf("v%0d_missing", v), {31'd0, s_missing}, vecs[v].exp_missing);
            if (vecs[v].readback != 0) begin
                for (int a = 0; a < 8; a++) begin
                    read_small(a, rd);
                    exp_pix = s_q.pop_front();
                    check_output($sformatf("v%0d_mem%0d", v, a), {24'd0, rd}, {24'd0, exp_pix});
                end
            end
        end

        // Reset in the middle of a frame, then a clean frame.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'(50 + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_output("midrst_count_before", {28'd0, s_count}, 3);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_busy",     {31'd0, s_busy},    0);
        check_output("midrst_ready",    {31'd0, s_ready},   0);
        check_output("midrst_count",    {28'd0, s_count},   0);
        check_output("midrst_checksum", s_checksum,         0);
        check_output("midrst_rd_data",  {24'd0, s_rd_data}, 0);
        @(negedge clk) rst_n = 1'b1;
        apply_stimulus(8, 8, 10, accepted);
        repeat (3) @(negedge clk);
        check_output("postrst_count",    {28'd0, s_count}, 8);
        check_output("postrst_checksum", s_checksum, 108);
        check_output("postrst_done",     s_done_pulses, 1);
        check_output("postrst_errs",     {30'd0, s_early, s_missing}, 0);

        // Throttled sink: random source gaps, three frames.
        t_stall_cycles = 0;
        for (int f = 0; f < 3; f++) begin
            t_q.delete();
            model_sum = 0;
            t_done_pulses = 0;
            @(posedge clk); #1 t_start = 1'b1;
            @(posedge clk); #1 t_start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                t_valid = 1'b0;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                t_valid = 1'b1;
                t_data  = 8'($urandom);
                t_last  = (i == 15);
                got = 1'b0;
                for (int w = 0; w < 50 && !got; w++) begin
                    @(negedge clk);
                    got = t_ready;
                    @(posedge clk); #1;
                end
                if (!got) begin
                    check_output($sformatf("stall_f%0d_beat%0d_timeout", f, i), 0, 1);
                    break;
                end
                t_q.push_back(t_data);
                model_sum += 32'(t_data);
            end
            t_valid = 1'b0;
            t_last  = 1'b0;
            repeat (3) @(negedge clk);
            check_output($sformatf("stall_f%0d_done", f), t_done_pulses, 1);
            check_output($sformatf("stall_f%0d_count", f), {27'd0, t_count}, 16);
            check_output($sformatf("stall_f%0d_checksum", f), t_checksum, model_sum);
            for (int a = 0; a < 16; a++) begin
                @(posedge clk); #1 t_rd_addr = 4'(a);
                @(posedge clk);
                @(negedge clk);
                exp_pix = t_q.pop_front();
                check_output($sformatf("stall_f%0d_mem%0d", f, a), {24'd0, t_rd_data}, {24'd0, exp_pix});
            end
        end
        check_output("stall_ready_throttled", {31'd0, (t_stall_cycles > 0)}, 1);

        // Long frame with the (i mod 256) pattern.
        model_sum = 0;
        b_done_pulses = 0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            b_valid = 1'b1;
            b_data  = 8'(i % 256);
            b_last  = (i == 19199);
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                got = b_ready;
                @(posedge clk); #1;
            end
            if (!got) begin
                check_output($sformatf("big_beat%0d_timeout", i), 0, 1);
                break;
            end
            model_sum += 32'(i % 256);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("big_done",     b_done_pulses, 1);
        check_output("big_count",    {16'd0, b_count}, 19200);
        check_output("big_checksum", b_checksum, model_sum);
        check_output("big_errs",     {30'd0, b_early, b_missing}, 0);
        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? 0 : ((k == 1) ? 1000 : 19199);
            @(posedge clk); #1 b_rd_addr = 15'(a);
            @(posedge clk);
            @(negedge clk);
            check_output($sformatf("big_mem%0d", a), {24'd0, b_rd_data}, a % 256);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscount);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit, got timeout, expected completion");
        miscount++;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscount);
        $fatal(1, "[TB] timeout");
    end

endmodule
